// File: rtl/e203_agu_icb_sram_rsp.sv
// AGU ICB responder backed by a word-organised local SRAM.
// It returns responses in order through a 2-entry queue and supports LR/SC reservations.
module e203_agu_icb_sram_rsp #(
  parameter int            AW         = 32,
  parameter int            DW         = 32,
  parameter int            DEPTH_LOG2 = 10,
  parameter logic [AW-1:0] BASE_ADDR  = 32'h9000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            agu_icb_cmd_valid,
  output logic            agu_icb_cmd_ready,
  input  logic [AW-1:0]   agu_icb_cmd_addr,
  input  logic            agu_icb_cmd_read,
  input  logic [DW-1:0]   agu_icb_cmd_wdata,
  input  logic [DW/8-1:0] agu_icb_cmd_wmask,
  input  logic            agu_icb_cmd_lock,
  input  logic            agu_icb_cmd_excl,
  input  logic [1:0]      agu_icb_cmd_size,
  output logic            agu_icb_rsp_valid,
  input  logic            agu_icb_rsp_ready,
  output logic            agu_icb_rsp_err,
  output logic            agu_icb_rsp_excl_ok,
  output logic [DW-1:0]   agu_icb_rsp_rdata
);

  localparam int MW    = DW / 8;
  localparam int IW    = DEPTH_LOG2;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DW-1:0] mem [DEPTH];

  logic [1:0]    count;
  logic          wr_ptr;
  logic          rd_ptr;
  logic          q_err     [2];
  logic          q_excl_ok [2];
  logic [DW-1:0] q_rdata   [2];

  logic          resv_vld;
  logic [IW-1:0] resv_idx;

  logic          vld_p0;
  logic          hit_p0;
  logic          misal_p0;
  logic          err_p0;
  logic [IW-1:0] idx_p0;
  logic          resv_hit_p0;
  logic          wen_p0;
  logic          excl_ok_p0;
  logic [DW-1:0] rdata_p0;
  logic          pop;

  // The lock attribute is accepted but has no effect on this memory.
  logic unused_lock;
  assign unused_lock = agu_icb_cmd_lock;

  // Stage p0: decode and execute the accepted command within the accept cycle.
  assign agu_icb_cmd_ready = (count != 2'd2);
  assign vld_p0      = agu_icb_cmd_valid & agu_icb_cmd_ready & ~rst;
  assign hit_p0      = (agu_icb_cmd_addr[AW-1:IW+2] == BASE_ADDR[AW-1:IW+2]);
  assign idx_p0      = agu_icb_cmd_addr[IW+1:2];

  always_comb begin
    misal_p0 = 1'b0;
    unique case (agu_icb_cmd_size)
      2'd0:    misal_p0 = 1'b0;
      2'd1:    misal_p0 = agu_icb_cmd_addr[0];
      2'd2:    misal_p0 = |agu_icb_cmd_addr[1:0];
      default: misal_p0 = 1'b1;
    endcase
  end

  assign err_p0      = ~hit_p0 | misal_p0;
  assign resv_hit_p0 = resv_vld & (resv_idx == idx_p0);
  assign wen_p0      = vld_p0 & ~agu_icb_cmd_read & ~err_p0 & (~agu_icb_cmd_excl | resv_hit_p0);
  assign excl_ok_p0  = vld_p0 & ~agu_icb_cmd_read & agu_icb_cmd_excl & ~err_p0 & resv_hit_p0;
  assign rdata_p0    = (agu_icb_cmd_read & ~err_p0) ? mem[idx_p0] : '0;
  assign pop         = agu_icb_rsp_valid & agu_icb_rsp_ready;

  always_ff @(posedge clk) begin
    if (wen_p0) begin
      for (int b = 0; b < MW; b++) begin
        if (agu_icb_cmd_wmask[b]) mem[idx_p0][8*b +: 8] <= agu_icb_cmd_wdata[8*b +: 8];
      end
    end
  end

  // Stage p1: the response queue holds results until the requester consumes them.
  always_ff @(posedge clk) begin
    if (vld_p0) begin
      q_err[wr_ptr]     <= err_p0;
      q_excl_ok[wr_ptr] <= excl_ok_p0;
      q_rdata[wr_ptr]   <= rdata_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (vld_p0 & agu_icb_cmd_read & agu_icb_cmd_excl & ~err_p0) resv_idx <= idx_p0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= 2'd0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      resv_vld <= 1'b0;
    end else begin
      unique case ({vld_p0, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (vld_p0) wr_ptr <= ~wr_ptr;
      if (pop)    rd_ptr <= ~rd_ptr;
      if (vld_p0 & ~err_p0) begin
        if (agu_icb_cmd_read & agu_icb_cmd_excl) resv_vld <= 1'b1;
        else if (~agu_icb_cmd_read & (agu_icb_cmd_excl | resv_hit_p0)) resv_vld <= 1'b0;
      end
    end
  end

  assign agu_icb_rsp_valid   = (count != 2'd0);
  assign agu_icb_rsp_err     = agu_icb_rsp_valid & q_err[rd_ptr];
  assign agu_icb_rsp_excl_ok = agu_icb_rsp_valid & q_excl_ok[rd_ptr];
  assign agu_icb_rsp_rdata   = agu_icb_rsp_valid ? q_rdata[rd_ptr] : '0;

endmodule

// File: tb/tb_e203_agu_icb_sram_rsp.sv
// Scoreboard bench for e203_agu_icb_sram_rsp: expected responses are queued at accept time
// and compared in order as the DUT pops them.
module tb_e203_agu_icb_sram_rsp;

  typedef struct packed {
    logic        err;
    logic        ok;
    logic [31:0] rdata;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic        cmd_read;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wmask;
  logic        cmd_lock;
  logic        cmd_excl;
  logic [1:0]  cmd_size;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_err;
  logic        rsp_excl_ok;
  logic [31:0] rsp_rdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;

  rsp_t sb[$];
  rsp_t hist[$];
  logic [31:0] model_mem [int];
  bit          m_resv_vld;
  int          m_resv_idx;

  e203_agu_icb_sram_rsp dut (
    .clk                 (clk),
    .rst                 (rst),
    .agu_icb_cmd_valid   (cmd_valid),
    .agu_icb_cmd_ready   (cmd_ready),
    .agu_icb_cmd_addr    (cmd_addr),
    .agu_icb_cmd_read    (cmd_read),
    .agu_icb_cmd_wdata   (cmd_wdata),
    .agu_icb_cmd_wmask   (cmd_wmask),
    .agu_icb_cmd_lock    (cmd_lock),
    .agu_icb_cmd_excl    (cmd_excl),
    .agu_icb_cmd_size    (cmd_size),
    .agu_icb_rsp_valid   (rsp_valid),
    .agu_icb_rsp_ready   (rsp_ready),
    .agu_icb_rsp_err     (rsp_err),
    .agu_icb_rsp_excl_ok (rsp_excl_ok),
    .agu_icb_rsp_rdata   (rsp_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic rsp_t model(input logic [31:0] a, input logic rd, input logic [31:0] wd,
                                 input logic [3:0] wm, input logic ex, input logic [1:0] sz);
    rsp_t r;
    bit hit, mis, match;
    int idx;
    logic [31:0] w;
    r   = '0;
    hit = (a[31:12] == 20'h90000);
    mis = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
    idx = int'(a[11:2]);
    if (!hit || mis) begin
      r.err = 1'b1;
      return r;
    end
    match = m_resv_vld && (m_resv_idx == idx);
    if (rd) begin
      r.rdata = model_mem.exists(idx) ? model_mem[idx] : 32'h0;
      if (ex) begin
        m_resv_vld = 1'b1;
        m_resv_idx = idx;
      end
    end else begin
      if (!ex || match) begin
        w = model_mem.exists(idx) ? model_mem[idx] : 32'h0;
        for (int b = 0; b < 4; b++) if (wm[b]) w[8*b +: 8] = wd[8*b +: 8];
        model_mem[idx] = w;
      end
      if (ex) begin
        r.ok = match;
        m_resv_vld = 1'b0;
      end else if (match) begin
        m_resv_vld = 1'b0;
      end
    end
    return r;
  endfunction

  // Response monitor: every pop is compared against the head of the scoreboard.
  always @(negedge clk) begin
    rsp_t got;
    rsp_t exp;
    if (!rst && rsp_valid && rsp_ready) begin
      got = {rsp_err, rsp_excl_ok, rsp_rdata};
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected got err=%0b ok=%0b rdata=%h, required no response", got.err, got.ok, got.rdata);
      end else begin
        exp = sb.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL rsp got err=%0b ok=%0b rdata=%h required err=%0b ok=%0b rdata=%h",
                   got.err, got.ok, got.rdata, exp.err, exp.ok, exp.rdata);
        end
      end
      hist.push_back(got);
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input logic [31:0] a, input logic rd, input logic [31:0] wd,
                      input logic [3:0] wm, input logic ex, input logic [1:0] sz);
    bit ok;
    ok        = 1'b0;
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_read  = rd;
    cmd_wdata = wd;
    cmd_wmask = wm;
    cmd_excl  = ex;
    cmd_size  = sz;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = cmd_ready;
      if (ok) begin
        acc_cyc = cyc;
        sb.push_back(model(a, rd, wd, wm, ex, sz));
      end
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout addr=%h not accepted within 50 cycles", a);
    end
  endtask

  task automatic drain();
    rsp_ready = 1'b1;
    for (int i = 0; i < 100 && sb.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout %0d responses outstanding, required 0", sb.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({cmd_ready, rsp_valid, rsp_err, rsp_excl_ok, rsp_rdata} !== {1'b1, 1'b0, 1'b0, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL reset_state got ready=%0b valid=%0b err=%0b ok=%0b rdata=%h required 1 0 0 0 0",
               cmd_ready, rsp_valid, rsp_err, rsp_excl_ok, rsp_rdata);
    end
    rst = 1'b0;
    m_resv_vld = 1'b0;
  endtask

  task automatic test_word();
    hist.delete();
    rsp_ready = 1'b1;
    send(32'h9000_0010, 1'b0, 32'hDEAD_BEEF, 4'hF, 1'b0, 2'd2);
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL latency rsp_valid=%0b one cycle after accept, required 1", rsp_valid);
    end
    send(32'h9000_0010, 1'b1, 32'h0, 4'h0, 1'b0, 2'd2);
    drain();
    checks++;
    if (hist.size() != 2 || hist[1] !== {1'b0, 1'b0, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL word_rw count=%0d last rdata=%h, required 2 responses rdata=deadbeef", hist.size(),
               hist.size() > 0 ? hist[hist.size()-1].rdata : 32'h0);
    end
  endtask

  task automatic test_bytemask();
    hist.delete();
    send(32'h9000_0012, 1'b0, 32'h00AA_0000, 4'h4, 1'b0, 2'd0);
    send(32'h9000_0010, 1'b1, 32'h0, 4'h0, 1'b0, 2'd2);
    drain();
    checks++;
    if (hist.size() != 2 || hist[1].rdata !== 32'hDEAA_BEEF) begin
      errors++;
      $display("FAIL byte_mask rdata=%h, required deaabeef", hist.size() == 2 ? hist[1].rdata : 32'h0);
    end
  endtask

  task automatic test_errors();
    send(32'h9000_0FFC, 1'b0, 32'h0BAD_F00D, 4'hF, 1'b0, 2'd2);
    drain();
    hist.delete();
    send(32'h8000_0000, 1'b1, 32'h0, 4'h0, 1'b0, 2'd2);
    send(32'h9000_0002, 1'b1, 32'h0, 4'h0, 1'b0, 2'd2);
    send(32'h9000_0FFE, 1'b0, 32'h1234_5678, 4'hF, 1'b0, 2'd2);
    send(32'h9000_0011, 1'b1, 32'h0, 4'h0, 1'b0, 2'd1);
    send(32'h9000_0010, 1'b1, 32'h0, 4'h0, 1'b0, 2'd3);
    send(32'h9000_0FFC, 1'b1, 32'h0, 4'h0, 1'b0, 2'd2);
    drain();
    checks++;
    if (hist.size() != 6 || {hist[0].err, hist[1].err, hist[2].err, hist[3].err, hist[4].err, hist[5].err} !== 6'b111110
        || hist[2].rdata !== 32'h0 || hist[5].rdata !== 32'h0BAD_F00D) begin
      errors++;
      $display("FAIL errors count=%0d final rdata=%h, required 6 responses errs 111110 final 0badf00d", hist.size(),
               hist.size() == 6 ? hist[5].rdata : 32'h0);
    end
  endtask

  task automatic test_lrsc();
    send(32'h9000_0020, 1'b0, 32'h1111_1111, 4'hF, 1'b0, 2'd2);
    drain();
    hist.delete();
    send(32'h9000_0020, 1'b1, 32'h0, 4'h0, 1'b1, 2'd2);
    send(32'h9000_0020, 1'b0, 32'd5, 4'hF, 1'b1, 2'd2);
    send(32'h9000_0020, 1'b0, 32'd6, 4'hF, 1'b1, 2'd2);
    send(32'h9000_0020, 1'b1, 32'h0, 4'h0, 1'b0, 2'd2);
    drain();
    checks++;
    if (hist.size() != 4 || hist[1].ok !== 1'b1 || hist[2].ok !== 1'b0 || hist[3].rdata !== 32'd5) begin
      errors++;
      $display("FAIL lr_sc count=%0d, required sc1 ok=1, sc2 ok=0, read 5", hist.size());
    end
    hist.delete();
    send(32'h9000_0020, 1'b1, 32'h0, 4'h0, 1'b1, 2'd2);
    send(32'h9000_0020, 1'b0, 32'd7, 4'hF, 1'b0, 2'd2);
    send(32'h9000_0020, 1'b0, 32'd9, 4'hF, 1'b1, 2'd2);
    send(32'h9000_0020, 1'b1, 32'h0, 4'h0, 1'b0, 2'd2);
    drain();
    checks++;
    if (hist.size() != 4 || hist[2].ok !== 1'b0 || hist[3].rdata !== 32'd7) begin
      errors++;
      $display("FAIL lr_write_sc count=%0d, required sc ok=0 and read 7", hist.size());
    end
  endtask

  task automatic test_back_to_back();
    int c0;
    send(32'h9000_0040, 1'b0, 32'hA0A0_0040, 4'hF, 1'b0, 2'd2);
    c0 = acc_cyc;
    send(32'h9000_0044, 1'b0, 32'hA0A0_0044, 4'hF, 1'b0, 2'd2);
    send(32'h9000_0048, 1'b0, 32'hA0A0_0048, 4'hF, 1'b0, 2'd2);
    send(32'h9000_0040, 1'b1, 32'h0, 4'h0, 1'b0, 2'd2);
    send(32'h9000_0044, 1'b1, 32'h0, 4'h0, 1'b0, 2'd2);
    send(32'h9000_0048, 1'b1, 32'h0, 4'h0, 1'b0, 2'd2);
    checks++;
    if (acc_cyc - c0 != 5) begin
      errors++;
      $display("FAIL throughput 6 accepts took %0d cycles, required 5", acc_cyc - c0);
    end
    drain();
  endtask

  task automatic test_backpressure();
    int pop_cyc;
    rsp_t hold;
    hist.delete();
    rsp_ready = 1'b0;
    send(32'h9000_0040, 1'b1, 32'h0, 4'h0, 1'b0, 2'd2);
    send(32'h9000_0044, 1'b1, 32'h0, 4'h0, 1'b0, 2'd2);
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_ready cmd_ready=%0b after two accepts, required 0", cmd_ready);
    end
    pop_cyc = 0;
    fork
      send(32'h9000_0048, 1'b1, 32'h0, 4'h0, 1'b0, 2'd2);
      begin
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          hold = {rsp_err, rsp_excl_ok, rsp_rdata};
          checks++;
          if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 || hold !== {1'b0, 1'b0, 32'hA0A0_0040}) begin
            errors++;
            $display("FAIL bp_hold valid=%0b ready=%0b rdata=%h, required 1 0 a0a00040", rsp_valid, cmd_ready, hold.rdata);
          end
        end
        @(posedge clk);
        #1;
        pop_cyc = cyc;
        rsp_ready = 1'b1;
      end
    join
    checks++;
    if (acc_cyc != pop_cyc + 1) begin
      errors++;
      $display("FAIL bp_third_accept at cycle %0d, required %0d", acc_cyc, pop_cyc + 1);
    end
    drain();
    checks++;
    if (hist.size() != 3 || hist[0].rdata !== 32'hA0A0_0040 || hist[1].rdata !== 32'hA0A0_0044 || hist[2].rdata !== 32'hA0A0_0048) begin
      errors++;
      $display("FAIL bp_order count=%0d, required in-order a0a00040/44/48", hist.size());
    end
  endtask

  task automatic test_reset_mid();
    send(32'h9000_0060, 1'b0, 32'h0000_0001, 4'hF, 1'b0, 2'd2);
    send(32'h9000_0060, 1'b1, 32'h0, 4'h0, 1'b1, 2'd2);
    drain();
    rsp_ready = 1'b0;
    send(32'h9000_0060, 1'b1, 32'h0, 4'h0, 1'b0, 2'd2);
    send(32'h9000_0060, 1'b1, 32'h0, 4'h0, 1'b0, 2'd2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    m_resv_vld = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid valid=%0b ready=%0b, required 0 1", rsp_valid, cmd_ready);
    end
    rsp_ready = 1'b1;
    hist.delete();
    send(32'h9000_0060, 1'b0, 32'h0000_0002, 4'hF, 1'b1, 2'd2);
    send(32'h9000_0060, 1'b1, 32'h0, 4'h0, 1'b0, 2'd2);
    drain();
    checks++;
    if (hist.size() != 2 || hist[0].ok !== 1'b0 || hist[1].rdata !== 32'h0000_0001) begin
      errors++;
      $display("FAIL reset_resv count=%0d, required sc ok=0 and read 00000001", hist.size());
    end
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr  = 32'h0;
    cmd_read  = 1'b0;
    cmd_wdata = 32'h0;
    cmd_wmask = 4'h0;
    cmd_lock  = 1'b0;
    cmd_excl  = 1'b0;
    cmd_size  = 2'd0;
    rsp_ready = 1'b1;
    m_resv_vld = 1'b0;
    m_resv_idx = 0;
    test_reset();
    test_word();
    test_bytemask();
    test_errors();
    test_lrsc();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
